// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit:
// op encodings, FSM state type and default datapath width.
package muldiv_pkg;

  localparam int WIDTH = 8;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned MUL/MULH/DIVU/REMU unit feeding the register file
// write port. Ports: clk, reset, start/op/a/b/dest in; busy/done/dz/wb_* out.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       dest,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             wb_we,
  output logic [2:0]       wb_wa,
  output logic [WIDTH-1:0] wb_wd
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   opa, opb;
  logic [1:0]         op_q;
  logic [2:0]         dest_q;
  logic [CW-1:0]      cnt;
  logic               dz_q;
  logic [WIDTH-1:0]   wd_q;
  logic [WIDTH-1:0]   res;
  logic               last;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_nx;

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiply: acc = {partial high, product bits shifted in from the top}.
  // Divide:   acc = {remainder, quotient bits shifted in at the bottom};
  //           the dividend streams MSB-first out of opa.
  always_comb begin
    acc_nx = acc;
    sum    = '0;
    trial  = '0;
    rem_nx = '0;
    if (!op_q[1]) begin
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (opb[0] ? {1'b0, opa} : '0);
      acc_nx = {sum, acc[WIDTH-1:1]};
    end else begin
      trial  = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
      rem_nx = trial[WIDTH-1:0] - opb;
      if (trial >= {1'b0, opb})
        acc_nx = {rem_nx, acc[WIDTH-2:0], 1'b1};
      else
        acc_nx = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      op_q   <= '0;
      dest_q <= '0;
      cnt    <= '0;
      dz_q   <= 1'b0;
      wd_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          opa    <= a;
          opb    <= b;
          op_q   <= op;
          dest_q <= dest;
          acc    <= '0;
          cnt    <= '0;
          dz_q   <= op[1] & (b == '0);
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (!op_q[1]) opb <= opb >> 1;
          else          opa <= opa << 1;
        end
        DONE:    wd_q <= res;
        default: ;
      endcase
    end
  end

  // High half carries MULH and REMU, low half MUL and DIVU.
  assign res   = op_q[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign wb_we = done;
  assign dz    = done & dz_q;
  assign wb_wa = dest_q;
  assign wb_wd = done ? res : wd_q;

endmodule

// File: doc/iter_muldiv.md
# iter_muldiv

Multi-cycle unsigned multiply/divide execute unit sitting directly downstream of the 8-bit register file. Consumes the two read-port operands plus a destination register address, iterates one bit per clock (shift-add multiply, restoring divide), then issues a single-cycle write-back (we/wa/wd) that drives the register file write port (we3/wa3/wd3). The controller holds operands stable only on the accepting cycle; the unit latches everything it needs.

## Interface
- WIDTH, 8, operand/result width; counter width is clog2(WIDTH)+1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL (low half), 01 MULH (high half), 10 DIVU (quotient), 11 REMU (remainder)
- a  in  WIDTH  multiplicand/dividend (register file rd1)
- b  in  WIDTH  multiplier/divisor (register file rd2)
- dest  in  3  destination register address
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- dz  out  1  divide-by-zero flag, valid while done is high, else 0
- wb_we  out  1  write-back enable to register file we3; equals done
- wb_wa  out  3  latched dest, to wa3
- wb_wd  out  WIDTH  result, to wd3; holds last result between operations

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 latches a, b, op, dest; clears 2*WIDTH accumulator and iteration counter; computes dz = (op[1] and b==0); goes to RUN. start=0 stays IDLE.
- RUN: one iteration per edge, exactly WIDTH iterations; the edge performing the last iteration moves to DONE.
  - Multiply: if multiplier LSB=1 add multiplicand into upper half of accumulator (with carry), shift accumulator right one, shift multiplier right.
  - Divide: shift {remainder, dividend} left one; if remainder >= divisor subtract and set quotient bit to 1, else 0.
- DONE: done=1, wb_we=1, wb_wd = selected result (MUL low WIDTH bits, MULH high WIDTH bits, DIVU quotient, REMU remainder); next edge returns to IDLE.
- Divide by zero: no special datapath; restoring algorithm naturally yields quotient all-ones, remainder = a; dz=1; write-back still performed.
- start while RUN or DONE: ignored, latched operands unchanged.
- Arithmetic unsigned throughout; no overflow flag.

## Timing
- Reset values: state IDLE, busy=0, done=0, dz=0, wb_we=0, wb_wa=0, wb_wd=0, accumulator and counter 0.
- start sampled at edge E0 → busy high from E0; iterations at E1..E(WIDTH); done/wb_we high for exactly the cycle between E(WIDTH) and E(WIDTH+1); busy low after E(WIDTH+1).
- Earliest next accept: edge E(WIDTH+2) (start held high gives one operation every WIDTH+2 cycles).
- wb_wa/wb_wd stable and valid during the done cycle; register file captures on E(WIDTH+1).
- reset asserted mid-RUN or during DONE: immediate return to IDLE, wb_we drops asynchronously, no write occurs; next start after reset release behaves normally.
- Fixed latency: independent of operand values and of dz.

## Structure
- Shared package muldiv_pkg: op encoding constants (OP_MUL, OP_MULH, OP_DIVU, OP_REMU), FSM state typedef, WIDTH default.
- Single module; no sub-module needed. Datapath (accumulator, operand shift registers, counter) and FSM in one file.

## Test plan
- MUL: a=0x0D, b=0x0B, op=00, dest=3 → done exactly 8 edges after accept, wb_we=1, wb_wa=3, wb_wd=0x8F, dz=0.
- MULH/MUL: a=0xFF, b=0xFF → op=01 gives wb_wd=0xFE; op=00 gives wb_wd=0x01.
- DIVU/REMU: a=0xC8, b=0x07 → op=10 gives 0x1C; op=11 gives 0x04.
- Divide by zero: a=0x5A, b=0x00 → op=10 gives 0xFF with dz=1; op=11 gives 0x5A with dz=1; MUL with b=0 gives 0x00, dz=0.
- Interference: accept 13*11, pulse start with a=0x02,b=0x02 at edge E3 → ignored, result 0x8F; then new op with reset at E5 → busy=0, wb_we never asserted, following MUL 3*5 returns 0x0F.
- Back-to-back: start held high with fixed operands → done pulses spaced exactly 10 cycles apart, each one cycle wide, busy low only one cycle between operations.
